// File: rtl/ws2811_pkg.sv
// Shared WS2811 definitions: line-state enum, pixel type and default timing
// constants, used by both the receive and transmit sides.
package ws2811_pkg;

  localparam int unsigned BIT_THRESH_DEF   = 40;
  localparam int unsigned MAX_HIGH_DEF     = 100;
  localparam int unsigned RESET_CYCLES_DEF = 2500;
  localparam int unsigned PIXEL_BITS       = 24;
  localparam int unsigned CNT_W            = 16;

  typedef logic [PIXEL_BITS-1:0] pixel_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  typedef enum logic [1:0] {
    WAIT_RST,
    IDLE,
    HIGH,
    LOW
  } ws_state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ws2811_rx_if.sv
// Decoded-pixel bus of the WS2811 receiver: data, strobes and frame pixel count.
interface ws2811_rx_if;
  import ws2811_pkg::*;

  pixel_t pixel_data;
  logic   pixel_valid;
  logic   frame_end;
  logic   bit_error;
  cnt_t   pixel_count;

  modport master (
    output pixel_data,
    output pixel_valid,
    output frame_end,
    output bit_error,
    output pixel_count
  );

  modport slave (
    input pixel_data,
    input pixel_valid,
    input frame_end,
    input bit_error,
    input pixel_count
  );

endinterface

// File: rtl/ws2811_sync_edge.sv
// Two-flop synchronizer for the asynchronous serial line plus a registered
// previous-value flop giving single-cycle rise/fall strobes.
module ws2811_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/ws2811_rx.sv
// WS2811 serial receiver: decodes pulse widths into 24-bit {G,R,B} pixels and
// frames. Define WS2811_RX_PASSTHRU_EN to act as one LED in a daisy chain.
module ws2811_rx
  import ws2811_pkg::*;
#(
  parameter int unsigned BIT_THRESH   = BIT_THRESH_DEF,
  parameter int unsigned MAX_HIGH     = MAX_HIGH_DEF,
  parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic        dout,
  ws2811_rx_if.master rx
);

  localparam cnt_t THRESH_C   = cnt_t'(BIT_THRESH);
  localparam cnt_t MAX_HIGH_C = cnt_t'(MAX_HIGH);
  localparam cnt_t RESET_C    = cnt_t'(RESET_CYCLES);
  localparam cnt_t LAST_BIT_C = cnt_t'(PIXEL_BITS - 1);

  logic sync;
  logic rise;
  logic fall;

  ws2811_sync_edge u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .sync  (sync),
    .rise  (rise),
    .fall  (fall)
  );

  ws_state_e state, state_n;
  cnt_t      high_cnt, high_cnt_n;
  cnt_t      low_cnt, low_cnt_n;
  cnt_t      bit_cnt, bit_cnt_n;
  logic [PIXEL_BITS-2:0] shift_q, shift_n;
  pixel_t    data_n;
  cnt_t      count_n;
  logic      valid_n, fe_n, err_n;
  logic      passing, pass_n;
  logic      bit_val;
  pixel_t    word;

  assign bit_val = (high_cnt >= THRESH_C);
  assign word    = {shift_q, bit_val};

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n    = state;
    high_cnt_n = high_cnt;
    low_cnt_n  = low_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_q;
    data_n     = rx.pixel_data;
    count_n    = rx.frame_end ? '0 : rx.pixel_count;
    valid_n    = 1'b0;
    fe_n       = 1'b0;
    err_n      = 1'b0;
    pass_n     = passing;

    unique case (state)
      WAIT_RST: begin
        if (sync)                    low_cnt_n = '0;
        else if (low_cnt >= RESET_C) state_n   = IDLE;
        else                         low_cnt_n = sat_inc(low_cnt);
      end

      // Widths count synchronized-line cycles, so the edge cycle itself is 1.
      IDLE: begin
        if (rise) begin
          high_cnt_n = cnt_t'(1);
          state_n    = HIGH;
        end
      end

      HIGH: begin
        if (fall) begin
          low_cnt_n = cnt_t'(1);
          state_n   = LOW;
          if (!passing) begin
            shift_n = word[PIXEL_BITS-2:0];
            if (bit_cnt == LAST_BIT_C) begin
              data_n    = word;
              valid_n   = 1'b1;
              bit_cnt_n = '0;
`ifdef WS2811_RX_PASSTHRU_EN
              count_n   = cnt_t'(1);
              pass_n    = 1'b1;
`else
              count_n   = sat_inc(rx.pixel_count);
`endif
            end else begin
              bit_cnt_n = sat_inc(bit_cnt);
            end
          end
        end else if (high_cnt >= MAX_HIGH_C) begin
          // Line still high after MAX_HIGH cycles: resynchronise on a reset gap.
          err_n     = 1'b1;
          state_n   = WAIT_RST;
          low_cnt_n = '0;
          bit_cnt_n = '0;
          shift_n   = '0;
          pass_n    = 1'b0;
        end else begin
          high_cnt_n = sat_inc(high_cnt);
        end
      end

      LOW: begin
        if (rise) begin
          high_cnt_n = cnt_t'(1);
          state_n    = HIGH;
        end else if (low_cnt >= RESET_C) begin
          fe_n      = 1'b1;
          err_n     = (bit_cnt != '0);
          bit_cnt_n = '0;
          shift_n   = '0;
          pass_n    = 1'b0;
          state_n   = IDLE;
        end else begin
          low_cnt_n = sat_inc(low_cnt);
        end
      end

      default: state_n = WAIT_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= WAIT_RST;
      high_cnt       <= '0;
      low_cnt        <= '0;
      bit_cnt        <= '0;
      shift_q        <= '0;
      passing        <= 1'b0;
      rx.pixel_data  <= '0;
      rx.pixel_valid <= 1'b0;
      rx.frame_end   <= 1'b0;
      rx.bit_error   <= 1'b0;
      rx.pixel_count <= '0;
    end else begin
      state          <= state_n;
      high_cnt       <= high_cnt_n;
      low_cnt        <= low_cnt_n;
      bit_cnt        <= bit_cnt_n;
      shift_q        <= shift_n;
      passing        <= pass_n;
      rx.pixel_data  <= data_n;
      rx.pixel_valid <= valid_n;
      rx.frame_end   <= fe_n;
      rx.bit_error   <= err_n;
      rx.pixel_count <= count_n;
    end
  end

`ifdef WS2811_RX_PASSTHRU_EN
  // Forwarding starts right after our own pixel and is cut at frame_end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= 1'b0;
    else        dout <= pass_n ? sync : 1'b0;
  end
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2811_rx.sv
// Randomized directed bench for ws2811_rx; the reference model derives pixels
// and frame events from the transmitted bit stream and pulse widths.
module tb_ws2811_rx;
  import ws2811_pkg::*;

`ifdef WS2811_RX_PASSTHRU_EN
  localparam bit PASSTHRU = 1'b1;
`else
  localparam bit PASSTHRU = 1'b0;
`endif
  localparam int RST_GAP = 2600;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic din   = 1'b0;
  logic dout;

  ws2811_rx_if bus ();

  ws2811_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .dout  (dout),
    .rx    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed events, sampled 1 time unit after each rising edge.
  logic [23:0] seen_data[$];
  logic [15:0] seen_cnt[$];
  int          fe_seen     = 0;
  int          err_seen    = 0;
  logic [15:0] fe_cnt_val  = '0;
  logic [15:0] post_fe_cnt = '0;
  logic        fe_err      = 1'b0;
  logic        fe_prev     = 1'b0;
  logic        d0 = 1'b0, d1 = 1'b0, d2 = 1'b0;
  logic        chk_dout    = 1'b0;
  int          dout_bad    = 0;

  always begin
    @(posedge clk);
    d2 = d1; d1 = d0; d0 = din;
    #1;
    if (rst_n) begin
      if (bus.pixel_valid) begin
        seen_data.push_back(bus.pixel_data);
        seen_cnt.push_back(bus.pixel_count);
      end
      if (fe_prev) post_fe_cnt = bus.pixel_count;
      if (bus.frame_end) begin
        fe_seen++;
        fe_cnt_val = bus.pixel_count;
        fe_err     = bus.bit_error;
      end
      if (bus.bit_error) err_seen++;
      if (dout !== ((PASSTHRU && chk_dout) ? d2 : 1'b0)) dout_bad++;
      fe_prev = bus.frame_end;
    end
  end

  // Reference model state.
  logic [23:0] exp_data[$];
  logic [15:0] exp_cnt[$];
  int          frame_px = 0;
  int          exp_fe   = 0;
  int          exp_err  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    @(negedge clk) din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // mode 0: random legal widths, 1: nominal 25/100 and 60/65, 2: 39/40 boundary.
  task automatic send_word(input logic [23:0] v, input int nbits, input int mode);
    int hi, lo;
    for (int i = 23; i > 23 - nbits; i--) begin
      case (mode)
        1:       begin hi = v[i] ? 60 : 25; lo = v[i] ? 65 : 100; end
        2:       begin hi = v[i] ? 40 : 39; lo = int'($urandom_range(80, 20)); end
        default: begin
          hi = v[i] ? int'($urandom_range(100, 40)) : int'($urandom_range(39, 6));
          lo = int'($urandom_range(90, 12));
        end
      endcase
      send_bit(v[i], hi, lo);
    end
  endtask

  // A complete pixel: every one is reported, except in chain mode where only
  // the first of a frame is, and the count then never exceeds 1.
  task automatic send_pixel(input logic [23:0] v, input int mode);
    send_word(v, 24, mode);
    frame_px++;
    if (!PASSTHRU || frame_px == 1) begin
      exp_data.push_back(v);
      exp_cnt.push_back(PASSTHRU ? 16'd1 : 16'(frame_px));
    end
  endtask

  task automatic compare_pixels(input string tag);
    check({tag, "_npix"}, 32'(seen_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < seen_data.size(); i++) begin
      check({tag, "_data"}, 32'(seen_data[i]), 32'(exp_data[i]));
      check({tag, "_cnt"},  32'(seen_cnt[i]),  32'(exp_cnt[i]));
    end
    seen_data.delete(); seen_cnt.delete();
    exp_data.delete();  exp_cnt.delete();
  endtask

  task automatic end_frame(input string tag, input logic pend_err);
    gap(RST_GAP);
    exp_fe++;
    if (pend_err) exp_err++;
    check({tag, "_fe_n"},    32'(fe_seen), 32'(exp_fe));
    check({tag, "_fe_cnt"},  32'(fe_cnt_val), PASSTHRU ? 32'(frame_px > 0) : 32'(frame_px));
    check({tag, "_fe_err"},  32'(fe_err), 32'(pend_err));
    check({tag, "_cnt_clr"}, 32'(post_fe_cnt), 32'd0);
    check({tag, "_err_n"},   32'(err_seen), 32'(exp_err));
    frame_px = 0;
  endtask

  initial begin
    logic [23:0] v;

    // Reset values.
    repeat (4) @(negedge clk);
    check("rst_data",  32'(bus.pixel_data),  32'd0);
    check("rst_valid", 32'(bus.pixel_valid), 32'd0);
    check("rst_fe",    32'(bus.frame_end),   32'd0);
    check("rst_err",   32'(bus.bit_error),   32'd0);
    check("rst_cnt",   32'(bus.pixel_count), 32'd0);
    check("rst_dout",  32'(dout),            32'd0);

    // Initial reset gap, then the nominal-width pixel.
    rst_n = 1'b1;
    gap(RST_GAP);
    send_pixel(24'hA50F3C, 1);
    chk_dout = 1'b1;
    gap(10);
    compare_pixels("nominal");

    // Three-pixel frame, frame_end once, no repeat in a long idle.
    send_pixel(24'($urandom), 0);
    send_pixel(24'($urandom), 0);
    gap(10);
    compare_pixels("frame3");
    end_frame("frame3", 1'b0);
    chk_dout = 1'b0;
    check("frame3_dout0", 32'(dout), 32'd0);
    gap(5000);
    check("idle_no_fe", 32'(fe_seen), 32'(exp_fe));

    // Boundary widths: 39 decodes 0, 40 decodes 1.
    v = 24'($urandom);
    v[1:0] = 2'b10;
    send_pixel(v, 2);
    gap(10);
    compare_pixels("thresh");
    end_frame("thresh", 1'b0);

    // Truncated pixel: error coincides with frame_end.
    send_word(24'($urandom), 10, 0);
    gap(10);
    compare_pixels("trunc");
    end_frame("trunc", 1'b1);

    // Over-long high: error, then nothing until a gap and fresh pixel.
    send_word(24'($urandom), 12, 0);
    send_bit(1'b1, 101, 50);
    exp_err++;
    check("long_err_n", 32'(err_seen), 32'(exp_err));
    send_word(24'($urandom), 24, 0);
    gap(50);
    compare_pixels("long_blocked");
    check("long_no_fe", 32'(fe_seen), 32'(exp_fe));
    gap(RST_GAP);
    send_pixel(24'($urandom), 0);
    gap(10);
    compare_pixels("long_recover");
    end_frame("long_recover", 1'b0);

    // Reset mid-pixel: no pulses, resync needs a full gap.
    send_word(24'($urandom), 10, 0);
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_cnt",  32'(bus.pixel_count), 32'd0);
    check("midrst_data", 32'(bus.pixel_data),  32'd0);
    rst_n = 1'b1;
    send_word(24'($urandom), 24, 0);
    gap(50);
    compare_pixels("midrst_blocked");
    check("midrst_err_n", 32'(err_seen), 32'(exp_err));
    gap(RST_GAP);
    send_pixel(24'($urandom), 0);
    gap(10);
    compare_pixels("midrst_recover");
    end_frame("midrst_recover", 1'b0);

    check("dout_trace", 32'(dout_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2811_rx.md
WS2811_RX -- requirements
Module: ws2811_rx

Interface
REQ-001 SHALL have parameter BIT_THRESH, default 40, minimum high-time in clk cycles decoded as a 1 (0.8 us at 50 MHz).
REQ-002 SHALL have parameter MAX_HIGH, default 100, high-time in cycles above which a pulse is illegal.
REQ-003 SHALL have parameter RESET_CYCLES, default 2500, low-time in cycles that marks a frame reset (50 us at 50 MHz).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port din, input, 1 bit, asynchronous WS2811 serial line.
REQ-007 SHALL have port pixel_data, output, 24 bits, last complete pixel in wire order {G,R,B}, MSB first.
REQ-008 SHALL have port pixel_valid, output, 1 bit, one-cycle pulse when pixel_data updates.
REQ-009 SHALL have port frame_end, output, 1 bit, one-cycle pulse on reset-gap detection.
REQ-010 SHALL have port bit_error, output, 1 bit, one-cycle pulse on an illegal pulse or a truncated pixel.
REQ-011 SHALL have port pixel_count, output, 16 bits, pixels completed in the current frame.
REQ-012 SHALL have port dout, output, 1 bit, daisy-chain forward line (see Configuration).

Function
REQ-013 SHALL pass din through a 2-flop synchronizer followed by a registered edge detector; all timing uses the synchronized signal.
REQ-014 SHALL implement states WAIT_RST, IDLE, HIGH and LOW.
REQ-015 WAIT_RST: count consecutive low cycles and go to IDLE when the count reaches RESET_CYCLES; any high restarts the count; no outputs pulse.
REQ-016 IDLE and LOW: a rising edge clears the high counter and enters HIGH.
REQ-017 HIGH: on a falling edge, decode bit = (high_cnt >= BIT_THRESH), shift it into the pixel shift register (MSB first), clear the low counter and enter LOW.
REQ-018 HIGH: if high_cnt exceeds MAX_HIGH, pulse bit_error, discard the partial pixel and enter WAIT_RST.
REQ-019 On the 24th bit, load pixel_data and pulse pixel_valid 1 cycle after the synchronized falling edge (3 clk after the din edge); increment pixel_count, saturating at 0xFFFF; clear the bit counter.
REQ-020 LOW: when low_cnt reaches RESET_CYCLES, pulse frame_end and enter IDLE.
- pixel_count holds its final value during the frame_end cycle and reads 0 on the next cycle.
- If 1 to 23 bits are pending, bit_error pulses in the same cycle as frame_end and the bits are discarded.
REQ-021 IDLE: a timeout does not pulse frame_end again (one frame_end per gap).
REQ-022 All counters SHALL be 16 bits and saturate; they never wrap.
REQ-023 pixel_data SHALL hold its value between pixel_valid pulses.

Reset
REQ-024 When rst_n is low, the state SHALL be WAIT_RST and pixel_data, pixel_valid, frame_end, bit_error, pixel_count, dout and all counters SHALL be 0.
REQ-025 A reset asserted mid-pixel SHALL abort the pixel without any pulse; after release, decoding waits for a full RESET_CYCLES low gap.

Configuration
REQ-026 With WS2811_RX_PASSTHRU_EN defined, the block SHALL behave as an LED in a chain.
- Only the first pixel of each frame is captured and reported.
- After that pixel's 24th falling edge, dout follows synchronized din (3-cycle delay) until frame_end.
- dout is forced to 0 at frame_end.
- pixel_count stays at most 1.
REQ-027 With WS2811_RX_PASSTHRU_EN undefined, dout SHALL be constant 0 and every pixel SHALL be reported.

Structure
REQ-028 A shared package ws2811_pkg SHALL hold the state enum, the 24-bit pixel typedef and the default timing constants, shared with the transmit side.
REQ-029 The synchronizer and edge detector SHALL be one sub-module, ws2811_sync_edge.

Verification
REQ-030 Stimulus: release reset, hold din low 2500 cycles, then send 0xA50F3C (0 = 25 high / 100 low, 1 = 60 high / 65 low). Required: one pixel_valid with pixel_data = 0xA50F3C and pixel_count = 1.
REQ-031 Stimulus: send 3 pixels, then hold low 2500 cycles. Required: frame_end pulses exactly once with pixel_count = 3, pixel_count = 0 on the next cycle, and a further 5000 low cycles give no second frame_end.
REQ-032 Stimulus: send 10 bits, then a 2500-cycle low gap. Required: bit_error and frame_end pulse in the same cycle, with no pixel_valid.
REQ-033 Stimulus: a 101-cycle high pulse mid-pixel. Required: bit_error pulses and no pixel_valid until a 2500-cycle low gap plus a fresh 24 bits.
REQ-034 Stimulus: boundary high widths of 39 and 40 cycles. Required: decoded as 0 and 1 respectively.
REQ-035 Stimulus: with WS2811_RX_PASSTHRU_EN defined, send 2 pixels. Required: only pixel 1 is reported, dout reproduces the pixel 2 waveform delayed by 3 cycles, and dout = 0 after frame_end.
